// File: rtl/multi_operand_entry_pkg.sv
// rtl/multi_operand_entry_pkg.sv - shared state codes and slot layout helper for operand entry
package multi_operand_entry_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        ENTER = 3'd1,
        FULL  = 3'd2
    } state_t;

    function automatic int slot_offset(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - rising-edge detector; history resets high so a button held through reset gives no edge
module edge_pulse (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/multi_operand_entry.sv
// rtl/multi_operand_entry.sv - keyed operand entry with undo, valid/consume handshake and error pulse
module multi_operand_entry
    import multi_operand_entry_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int COUNT = 2,
    localparam int IDX_W = $clog2(COUNT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     confirm,
    input  logic                     undo,
    input  logic [WIDTH-1:0]         in,
    input  logic                     consume,
    output logic [STATE_W-1:0]       state,
    output logic [IDX_W-1:0]         index,
    output logic [COUNT*WIDTH-1:0]   operands,
    output logic                     valid,
    output logic                     error
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    logic             cf;
    logic             ud;
    state_t           state_q;
    logic [IDX_W-1:0] index_q;
    logic [WIDTH-1:0] slots [COUNT];
    logic             valid_q;
    logic             error_q;

    edge_pulse u_confirm_edge (
        .clock (clock),
        .reset (reset),
        .level (confirm),
        .pulse (cf)
    );

    edge_pulse u_undo_edge (
        .clock (clock),
        .reset (reset),
        .level (undo),
        .pulse (ud)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            for (int k = 0; k < COUNT; k++) begin
                slots[k] <= '0;
            end
        end else begin
            error_q <= 1'b0;
            case (state_q)
                // Edges in the first cycle after reset are swallowed silently.
                IDLE: begin
                    state_q <= ENTER;
                end
                ENTER: begin
                    if (cf && ud) begin
                        error_q <= 1'b1;
                    end else if (cf) begin
                        slots[index_q] <= in;
                        if (index_q == LAST) begin
                            state_q <= FULL;
                            valid_q <= 1'b1;
                        end else begin
                            index_q <= index_q + IDX_W'(1);
                        end
                    end else if (ud) begin
                        if (index_q != '0) begin
                            index_q <= index_q - IDX_W'(1);
                            slots[index_q - IDX_W'(1)] <= '0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    // consume outranks any button edge seen in the same cycle
                    if (consume) begin
                        state_q <= ENTER;
                        index_q <= '0;
                        valid_q <= 1'b0;
                        for (int k = 0; k < COUNT; k++) begin
                            slots[k] <= '0;
                        end
                    end else if (ud) begin
                        state_q        <= ENTER;
                        valid_q        <= 1'b0;
                        slots[COUNT-1] <= '0;
                    end else if (cf) begin
                        error_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    error_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < COUNT; k++) begin : g_flatten
        assign operands[slot_offset(k, WIDTH) +: WIDTH] = slots[k];
    end

    assign state = state_q;
    assign index = index_q;
    assign valid = valid_q;
    assign error = error_q;

endmodule

// File: doc/multi_operand_entry.md
Name: multi_operand_entry

Overview:
Parametrised operand-entry controller. The user keys COUNT operands of WIDTH bits one at a time on a shared input bus, confirming each with a button. It adds per-operand undo, a valid/consume handshake toward the downstream datapath, and an error pulse for illegal actions. It sits between the board switches/buttons and the arithmetic/display logic, which reads the flattened operand bus.

Parameters:
WIDTH, 4, bits per operand (1..16)
COUNT, 2, number of operands captured per transaction (2..16)
IDX_W, $clog2(COUNT), derived localparam; width of index, not overridable

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
confirm  input  1  level button; rising edge captures in into current slot
undo  input  1  level button; rising edge steps back one slot
in  input  WIDTH  operand value from switches
consume  input  1  one-cycle pulse from downstream: operands taken
state  output  3  FSM state code
index  output  IDX_W  slot the next confirm will write
operands  output  COUNT*WIDTH  slot k at bits [k*WIDTH +: WIDTH]
valid  output  1  all COUNT slots filled and held stable
error  output  1  one-cycle pulse on an illegal action

Behaviour:
- One clock; reset is synchronous and active-high, ports named clock and reset.
- Reset values: state=IDLE, index=0, operands=0, valid=0, error=0, edge-detector history registers=1. A button held through reset produces no edge.
- Edge detect: cf = confirm & ~confirm_q, ud = undo & ~undo_q. Both are combinational from registered history. The action takes effect at the same clock edge; results are visible the cycle after the button rises.
- State codes: IDLE=3'd0, ENTER=3'd1, FULL=3'd2. Codes 3..7 are illegal and return to IDLE on the next edge with error=1.
- IDLE: lasts exactly one cycle after reset deasserts. Edges in this cycle are ignored without error. Next state is ENTER.
- ENTER:
  - cf & ~ud: slot[index] <= in.
    - If index==COUNT-1: go to FULL and set valid=1; index stays COUNT-1.
    - Else: index+1.
  - ud & ~cf:
    - If index>0: index-1 and slot[index-1] <= 0.
    - If index==0: no change, error pulse.
  - cf & ud in the same cycle: both ignored, error pulse.
  - consume in ENTER: ignored, no error.
- FULL:
  - valid=1 and operands frozen.
  - consume (takes priority over any button edge): all slots <= 0, index <= 0, valid <= 0, go to ENTER.
  - ud (no consume): slot[COUNT-1] <= 0, valid <= 0, index stays COUNT-1, go to ENTER.
  - cf (no consume, no ud): ignored, error pulse.
- error is high for exactly one cycle per offending edge and never high during reset.
- valid and state change on the same edge; valid==1 iff state==FULL.
- Reset mid-transaction clears everything identically to power-up, regardless of state.
- in is sampled only on cf cycles. Changes on in at other times have no effect.

Decomposition:
- Shared package holds: state code localparams (IDLE/ENTER/FULL, 3 bits), the width of the state encoding, and the slot-offset helper (k*WIDTH).
- One sub-module, edge_pulse (1-bit rising-edge detector with synchronous active-high reset to 1). Instantiate it twice, for confirm and undo.
- Operand storage is an internal array flattened onto operands. No separate register instances.

Test Plan:
- Reset held 3 cycles with confirm=1 -> after release state=0 for 1 cycle then 1, no operand written, error=0, operands=0.
- WIDTH=4, COUNT=2: in=4'hA, confirm pulse; in=4'h5, confirm pulse -> operands=8'h5A, index=1, state=2, valid=1 one cycle after second edge.
- COUNT=3, WIDTH=8: enter 8'h11, 8'h22; undo -> index=1, slot1=0; enter 8'h33, 8'h44 -> operands=24'h443311, valid=1.
- In FULL (COUNT=2, operands=8'h5A): confirm edge -> error=1 for 1 cycle, operands unchanged; then consume and undo in the same cycle -> operands=0, index=0, state=1, valid=0, error=0.
- At index=0: undo edge -> error pulse, index=0; confirm and undo rising in the same cycle at index=1 -> error pulse, slot1 unchanged, index=1.
- Confirm held high 10 cycles with in changing every cycle -> exactly one capture (value at the rising cycle), index advances by 1 only.
